// File: rtl/mult_ctrl_taint_seq_pkg.sv
// Shared types and helpers for the taint-tracking shift-add multiplier control.
package mult_taint_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_BIT   = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  function automatic int unsigned idx_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic taint_or(input logic a, input logic b);
    return a | b;
  endfunction

endpackage

// File: rtl/mult_ctrl_taint_seq_if.sv
// Handshake, operand and strobe bundle between the multiplier control and its peers.
interface mult_ctrl_taint_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             start_t;
  logic             ack;
  logic             ack_t;
  logic [WIDTH-1:0] multiplierReg;
  logic [WIDTH-1:0] multiplierReg_t;
  logic             busy;
  logic             busy_t;
  logic             productDone;
  logic             productDone_t;
  logic             mdld;
  logic             mdld_t;
  logic             mrld;
  logic             mrld_t;
  logic             rsclear;
  logic             rsclear_t;
  logic             rsload;
  logic             rsload_t;
  logic             rsshr;
  logic             rsshr_t;

  modport master (
    output start, start_t, ack, ack_t, multiplierReg, multiplierReg_t,
    input  busy, busy_t, productDone, productDone_t, mdld, mdld_t,
           mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t
  );

  modport slave (
    input  start, start_t, ack, ack_t, multiplierReg, multiplierReg_t,
    output busy, busy_t, productDone, productDone_t, mdld, mdld_t,
           mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t
  );
endinterface

// File: rtl/mult_ctrl_taint_seq_bit_counter.sv
// Binary bit-index counter with last-bit flag and a single control-taint bit.
module mult_bit_counter_taint
  import mult_taint_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_t_d,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic             o_t
);

  logic [IDX_W-1:0] r_idx;
  logic             r_t;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
      r_t   <= 1'b0;
    end else begin
      if (i_clr) begin
        r_idx <= '0;
      end else if (i_inc) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      r_t <= i_t_d;
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_idx == IDX_W'(WIDTH - 1));
  assign o_t    = r_t;

endmodule

// File: rtl/mult_ctrl_taint_seq.sv
// Shift-add multiplier control FSM: one BIT/ADD/SHIFT pass per operand bit, done held until ack.
module mult_ctrl_taint_seq
  import mult_taint_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter bit          STICKY_TAINT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  mult_ctrl_taint_seq_if.slave   bus
);

  localparam int unsigned IDX_W = idx_w(WIDTH);

  state_e           r_state;
  state_e           w_next;
  logic             w_next_t;
  logic [IDX_W-1:0] w_idx;
  logic             w_last;
  logic             w_t;

  logic r_busy;
  logic r_done;
  logic r_ld;
  logic r_rsload;
  logic r_rsshr;

  always_comb begin
    w_next   = r_state;
    w_next_t = w_t;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_INIT;
        w_next_t = STICKY_TAINT ? taint_or(w_t, bus.start_t) : bus.start_t;
      end
      S_INIT:  w_next = S_BIT;
      S_BIT: begin
        w_next   = bus.multiplierReg[w_idx] ? S_ADD : S_SHIFT;
        w_next_t = taint_or(w_t, bus.multiplierReg_t[w_idx]);
      end
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = w_last ? S_DONE : S_BIT;
      S_DONE: begin
        if (bus.ack) w_next = S_IDLE;
        w_next_t = taint_or(w_t, bus.ack_t);
      end
      default: w_next = S_IDLE;
    endcase
  end

  mult_bit_counter_taint #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (r_state == S_INIT),
    .i_inc   ((r_state == S_SHIFT) && !w_last),
    .i_t_d   (w_next_t),
    .o_idx   (w_idx),
    .o_last  (w_last),
    .o_t     (w_t)
  );

  // Strobes are decoded from the next state so they register in step with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ld     <= 1'b0;
      r_rsload <= 1'b0;
      r_rsshr  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_DONE);
      r_ld     <= (w_next == S_INIT);
      r_rsload <= (w_next == S_ADD);
      r_rsshr  <= (w_next == S_SHIFT);
    end
  end

  assign bus.busy          = r_busy;
  assign bus.productDone   = r_done;
  assign bus.mdld          = r_ld;
  assign bus.mrld          = r_ld;
  assign bus.rsclear       = r_ld;
  assign bus.rsload        = r_rsload;
  assign bus.rsshr         = r_rsshr;
  assign bus.busy_t        = w_t;
  assign bus.productDone_t = w_t;
  assign bus.mdld_t        = w_t;
  assign bus.mrld_t        = w_t;
  assign bus.rsclear_t     = w_t;
  assign bus.rsload_t      = w_t;
  assign bus.rsshr_t       = w_t;

endmodule

// File: tb/tb_mult_ctrl_taint_seq.sv
// Bench for mult_ctrl_taint_seq: sticky and per-op taint DUTs against an operation-plan model.
module tb_mult_ctrl_taint_seq;

  localparam int unsigned W = 4;

  typedef enum int {P_IDLE, P_INIT, P_BIT, P_ADD, P_SHIFT, P_DONE} phase_e;
  typedef struct {
    phase_e      ph;
    int unsigned bitn;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0, start_t = 1'b0, ack = 1'b0, ack_t = 1'b0;
  logic [W-1:0] mr = '0, mt = '0;

  mult_ctrl_taint_seq_if #(.WIDTH(W)) if0 ();
  mult_ctrl_taint_seq_if #(.WIDTH(W)) if1 ();

  assign if0.start = start;  assign if0.start_t = start_t;
  assign if0.ack   = ack;    assign if0.ack_t   = ack_t;
  assign if0.multiplierReg = mr; assign if0.multiplierReg_t = mt;
  assign if1.start = start;  assign if1.start_t = start_t;
  assign if1.ack   = ack;    assign if1.ack_t   = ack_t;
  assign if1.multiplierReg = mr; assign if1.multiplierReg_t = mt;

  mult_ctrl_taint_seq #(.WIDTH(W), .STICKY_TAINT(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  mult_ctrl_taint_seq #(.WIDTH(W), .STICKY_TAINT(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  int unsigned n_chk = 0, n_pass = 0;

  // Model: an accepted start expands into the full step plan for the operand.
  step_t       plan[$];
  phase_e      m_ph = P_IDLE;
  int unsigned m_bit = 0;
  logic        m_t[2] = '{1'b0, 1'b0};

  bit          op_live = 1'b0;
  int unsigned op_cyc, op_loads, op_shrs, op_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] strobes0();
    return {if0.busy, if0.productDone, if0.mdld, if0.mrld, if0.rsclear, if0.rsload, if0.rsshr};
  endfunction
  function automatic logic [6:0] strobes1();
    return {if1.busy, if1.productDone, if1.mdld, if1.mrld, if1.rsclear, if1.rsload, if1.rsshr};
  endfunction
  function automatic logic [6:0] taints0();
    return {if0.busy_t, if0.productDone_t, if0.mdld_t, if0.mrld_t, if0.rsclear_t, if0.rsload_t, if0.rsshr_t};
  endfunction
  function automatic logic [6:0] taints1();
    return {if1.busy_t, if1.productDone_t, if1.mdld_t, if1.mrld_t, if1.rsclear_t, if1.rsload_t, if1.rsshr_t};
  endfunction

  task automatic model_step();
    step_t s;
    for (int d = 0; d < 2; d++) begin
      case (m_ph)
        P_IDLE: m_t[d] = (d == 0) ? (m_t[d] | start_t) : start_t;
        P_BIT:  m_t[d] = m_t[d] | mt[m_bit];
        P_DONE: m_t[d] = m_t[d] | ack_t;
        default: ;
      endcase
    end
    if (m_ph == P_IDLE) begin
      if (start) begin
        plan.push_back('{P_INIT, 0});
        for (int i = 0; i < int'(W); i++) begin
          plan.push_back('{P_BIT, i});
          if (mr[i]) plan.push_back('{P_ADD, i});
          plan.push_back('{P_SHIFT, i});
        end
        plan.push_back('{P_DONE, 0});
        op_live  = 1'b1;
        op_cyc   = 0;
        op_loads = 0;
        op_shrs  = 0;
        op_pop   = $countones(mr);
      end
    end else if (m_ph == P_DONE) begin
      if (ack) m_ph = P_IDLE;
    end
    if ((m_ph == P_IDLE && start) || (m_ph != P_IDLE && m_ph != P_DONE)) begin
      s     = plan.pop_front();
      m_ph  = s.ph;
      m_bit = s.bitn;
    end
  endtask

  task automatic expect_now();
    logic [6:0] exp;
    logic [6:0] o0;
    exp = {m_ph != P_IDLE, m_ph == P_DONE, m_ph == P_INIT, m_ph == P_INIT,
           m_ph == P_INIT, m_ph == P_ADD, m_ph == P_SHIFT};
    o0  = strobes0();
    check("strobes_sticky", 32'(o0), 32'(exp));
    check("strobes_perop", 32'(strobes1()), 32'(exp));
    check("taint_sticky", 32'(taints0()), 32'({7{m_t[0]}}));
    check("taint_perop", 32'(taints1()), 32'({7{m_t[1]}}));
    if (op_live) begin
      if (o0[6] && !o0[5]) begin
        op_cyc++;
        if (o0[1]) op_loads++;
        if (o0[0]) op_shrs++;
      end else if (o0[5]) begin
        check("done_latency", op_cyc, 1 + 2 * W + op_pop);
        check("rsload_count", op_loads, op_pop);
        check("rsshr_count", op_shrs, W);
        op_live = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic st, input logic a, input logic at,
                       input logic [W-1:0] mrv, input logic [W-1:0] mtv);
    @(negedge clk);
    start = s; start_t = st; ack = a; ack_t = at; mr = mrv; mt = mtv;
    @(posedge clk);
    model_step();
    #1;
    expect_now();
  endtask

  task automatic op(input logic [W-1:0] mrv, input logic [W-1:0] mtv, input logic st,
                    input int unsigned hold, input logic at);
    int unsigned n;
    cycle(1'b1, st, 1'b0, 1'b0, mrv, mtv);
    n = 0;
    while (m_ph != P_DONE && n < 100) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, mrv, mtv);
      n++;
    end
    if (n >= 100) check("op_reaches_done", 32'd0, 32'd1);
    for (int i = 0; i < int'(hold); i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, mrv, mtv);
    cycle(1'b0, 1'b0, 1'b1, at, mrv, mtv);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, mrv, mtv);
  endtask

  task automatic model_reset();
    plan.delete();
    m_ph    = P_IDLE;
    m_bit   = 0;
    m_t[0]  = 1'b0;
    m_t[1]  = 1'b0;
    op_live = 1'b0;
  endtask

  task automatic reset_mid_add(input logic [W-1:0] mrv);
    int unsigned n;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, mrv, '1);
    n = 0;
    while (m_ph != P_ADD && n < 50) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, mrv, '1);
      n++;
    end
    if (n >= 50) check("reach_add", 32'd0, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_strobes0", 32'(strobes0()), 32'd0);
    check("async_rst_strobes1", 32'(strobes1()), 32'd0);
    check("async_rst_taint0", 32'(taints0()), 32'd0);
    check("async_rst_taint1", 32'(taints1()), 32'd0);
    model_reset();
    @(negedge clk);
    start = 1'b0; start_t = 1'b0; ack = 1'b0; ack_t = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    expect_now();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, mrv, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rmr, rmt;
    #12;
    check("reset_strobes", 32'({strobes0(), strobes1()}), 32'd0);
    check("reset_taint", 32'({taints0(), taints1()}), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); model_step(); #1; expect_now();

    op(4'b0101, 4'b0000, 1'b0, 0, 1'b0);
    op(4'b0000, 4'b0100, 1'b0, 0, 1'b0);
    op(4'b0011, 4'b1000, 1'b0, 0, 1'b0);
    reset_mid_add(4'b1111);
    op(4'b1001, 4'b0000, 1'b1, 0, 1'b0);
    op(4'b1001, 4'b0000, 1'b0, 0, 1'b0);
    reset_mid_add(4'b0110);
    op(4'b0110, 4'b0000, 1'b0, 5, 1'b1);

    // start and ack held together through DONE exit
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0000);
    for (int i = 0; i < 40 && m_ph != P_DONE; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0000);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0000);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0000);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0000);

    rmr = $urandom; rmt = '0;
    for (int i = 0; i < 600; i++) begin
      if (m_ph == P_IDLE) begin
        rmr = W'($urandom);
        rmt = (($urandom % 4) == 0) ? W'($urandom) : '0;
      end
      cycle(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 3) == 0,
            ($urandom % 6) == 0, rmr, rmt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
